lcd_bitmap_overlay: RTL

- Downstream consumer of the 64x1 bitmap SDPB, which holds an 8x8 1-bit icon (bit address = row*8 + col).
- Sits in the RGB565 LCD pixel path just before the LCD output registers.
- Tracks the pixel x/y position, drives the SDPB read port, and replaces pixels under set bitmap bits with a foreground colour.
- The icon is scaled by 2^SCALE_LOG2 in both axes and placed at a run-time position.

---
 rtl/lcd_pkg.sv | 12 +
 rtl/lcd_pos_counter.sv | 44 ++++
 rtl/lcd_bitmap_overlay.sv | 94 +++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// lcd_pkg: shared RGB565 pixel-path constants, sync FSM type and vsync polarity helper.
package lcd_pkg;
  localparam int RGB_W    = 16;
  localparam int H_ACTIVE = 800;
  localparam int V_ACTIVE = 480;

  typedef enum logic {UNSYNC, SYNCED} lcd_state_e;

  function automatic logic vs_asserted(input logic vs, input logic active_low);
    return active_low ? ~vs : vs;
  endfunction
endpackage

// File: rtl/lcd_pos_counter.sv
// lcd_pos_counter: saturating pixel x/y position counters with vsync and data-enable edge detection.
module lcd_pos_counter
  import lcd_pkg::*;
#(
  parameter int H_ACTIVE = lcd_pkg::H_ACTIVE,
  parameter int V_ACTIVE = lcd_pkg::V_ACTIVE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        de_i,
  input  logic        vs_act_i,
  output logic [10:0] x_o,
  output logic [10:0] y_o,
  output logic        vs_edge_o
);
  logic        de_q, vs_q;
  logic [10:0] x_d, y_d;

  assign vs_edge_o = vs_act_i & ~vs_q;

  // a frame start wins over any simultaneous pixel or line-end update
  always_comb begin
    x_d = vs_edge_o ? 11'd0 :
          de_i      ? ((x_o == 11'(H_ACTIVE - 1)) ? x_o : x_o + 11'd1) :
          de_q      ? 11'd0 : x_o;
    y_d = vs_edge_o ? 11'd0 :
          (de_q & ~de_i & (y_o != 11'(V_ACTIVE - 1))) ? y_o + 11'd1 : y_o;
  end

  // vs_q resets asserted so a reset released mid-pulse waits for the next pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_o  <= '0;
      y_o  <= '0;
      de_q <= 1'b0;
      vs_q <= 1'b1;
    end else begin
      x_o  <= x_d;
      y_o  <= y_d;
      de_q <= de_i;
      vs_q <= vs_act_i;
    end
  end
endmodule

// File: rtl/lcd_bitmap_overlay.sv
// lcd_bitmap_overlay: overlays a scaled 8x8 1-bit icon read from an SDPB onto the RGB565 pixel stream.
module lcd_bitmap_overlay
  import lcd_pkg::*;
#(
  parameter int H_ACTIVE      = lcd_pkg::H_ACTIVE,
  parameter int V_ACTIVE      = lcd_pkg::V_ACTIVE,
  parameter int SCALE_LOG2    = 2,
  parameter bit VS_ACTIVE_LOW = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_de,
  input  logic             in_hs,
  input  logic             in_vs,
  input  logic [RGB_W-1:0] in_rgb,
  input  logic             ovl_en,
  input  logic [10:0]      pos_x,
  input  logic [10:0]      pos_y,
  input  logic [RGB_W-1:0] fg_rgb,
  output logic [5:0]       mem_adb,
  output logic             mem_ceb,
  output logic             mem_oce,
  input  logic             mem_dout,
  output logic             out_de,
  output logic             out_hs,
  output logic             out_vs,
  output logic [RGB_W-1:0] out_rgb
);
  localparam logic [11:0] WIN = 12'(8 << SCALE_LOG2);

  lcd_state_e       state_q, state_d;
  logic             en_q, vs_act, vs_edge, win;
  logic             de1_q, hs1_q, vs1_q, win1_q;
  logic [10:0]      sx_q, sy_q, x, y;
  logic [11:0]      dx, dy;
  logic [RGB_W-1:0] fg_q, rgb1_q;

  assign vs_act = vs_asserted(in_vs, VS_ACTIVE_LOW);

  lcd_pos_counter #(.H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE)) u_pos (
    .clk      (clk),
    .rst_n    (rst_n),
    .de_i     (in_de),
    .vs_act_i (vs_act),
    .x_o      (x),
    .y_o      (y),
    .vs_edge_o(vs_edge)
  );

  // 12-bit offsets: a pixel left of or above the window wraps to a large value
  assign dx      = {1'b0, x} - {1'b0, sx_q};
  assign dy      = {1'b0, y} - {1'b0, sy_q};
  assign win     = en_q & (state_q == SYNCED) & (dx < WIN) & (dy < WIN);
  assign mem_adb = {dy[SCALE_LOG2 +: 3], dx[SCALE_LOG2 +: 3]};
  assign mem_ceb = in_de & win;
  assign mem_oce = 1'b1;
  assign state_d = vs_edge ? SYNCED : state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= UNSYNC;
      en_q    <= 1'b0;
      sx_q    <= '0;
      sy_q    <= '0;
      fg_q    <= '0;
      de1_q   <= 1'b0;
      hs1_q   <= 1'b0;
      vs1_q   <= 1'b0;
      win1_q  <= 1'b0;
      rgb1_q  <= '0;
      out_de  <= 1'b0;
      out_hs  <= 1'b0;
      out_vs  <= 1'b0;
      out_rgb <= '0;
    end else begin
      state_q <= state_d;
      if (vs_edge) begin
        en_q <= ovl_en;
        sx_q <= pos_x;
        sy_q <= pos_y;
        fg_q <= fg_rgb;
      end
      de1_q   <= in_de;
      hs1_q   <= in_hs;
      vs1_q   <= in_vs;
      win1_q  <= win & in_de;
      rgb1_q  <= in_rgb;
      out_de  <= de1_q;
      out_hs  <= hs1_q;
      out_vs  <= vs1_q;
      out_rgb <= (win1_q & mem_dout) ? fg_q : rgb1_q;
    end
  end
endmodule
